// File: rtl/dp_issue_ctrl.sv
// Issue controller for the 16-bit lab datapath: command FIFO, issue FSM,
// ALU-latency tracking pipe and tagged result capture.
module dp_issue_ctrl #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ALU_LAT   = 1,
    parameter logic [3:0]  HALT_OP   = 4'hF,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_is_init,
    input  logic [15:0] cmd_instr,
    input  logic [15:0] cmd_data,
    output logic [15:0] dp_instr,
    output logic [15:0] dp_data_init,
    output logic        dp_init_sel,
    input  logic [15:0] alu_out,
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic [7:0]  res_tag,
    output logic        busy,
    output logic        done
);

    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned CW   = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;

    typedef struct packed {
        logic        is_init;
        logic [15:0] instr;
        logic [15:0] data;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    cmd_t              fifo_mem [DEPTH];
    cmd_t              head;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CNTW-1:0]   count, count_d;
    logic              push, pop, halt_pop, track_d;
    logic [15:0]       instr_d, data_d;
    logic              sel_d;
    logic [CW-1:0]     drain_cnt;
    logic [7:0]        tag;
    logic [ALU_LAT-1:0] pipe_vld;
    logic [7:0]        pipe_tag [ALU_LAT];

    assign push    = cmd_valid && cmd_ready;
    assign head    = fifo_mem[rd_ptr];
    assign count_d = count + CNTW'(push) - CNTW'(pop);

    // Next state, pop decision and next datapath drive values.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        halt_pop = 1'b0;
        track_d  = 1'b0;
        instr_d  = NOP_INSTR;
        data_d   = 16'h0000;
        sel_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (count != '0) begin
                    pop = 1'b1;
                    if (head.instr[15:12] == HALT_OP) begin
                        halt_pop = 1'b1;
                        state_d  = DRAIN;
                    end else begin
                        instr_d = head.instr;
                        data_d  = head.data;
                        sel_d   = head.is_init;
                        track_d = !head.is_init;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) state_d = DONE;
            end
            DONE: begin
                if (start) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Command storage; contents need no reset since count guards them.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{is_init: cmd_is_init, instr: cmd_instr, data: cmd_data};
    end

    // State, FIFO pointers, datapath drive, tag and drain counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            cmd_ready    <= 1'b1;
            dp_instr     <= NOP_INSTR;
            dp_data_init <= 16'h0000;
            dp_init_sel  <= 1'b0;
            tag          <= 8'h00;
            drain_cnt    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            count        <= count_d;
            cmd_ready    <= (count_d != CNTW'(DEPTH));
            dp_instr     <= instr_d;
            dp_data_init <= data_d;
            dp_init_sel  <= sel_d;
            busy         <= (state_d == RUN) || (state_d == DRAIN);
            done         <= (state_d == DONE);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (track_d) tag <= tag + 8'd1;
            if (halt_pop) begin
                drain_cnt <= CW'(ALU_LAT - 1);
            end else if ((state_q == DRAIN) && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - CW'(1);
            end
        end
    end

    // Latency pipe of {valid, tag} and tagged result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld  <= '0;
            res_valid <= 1'b0;
            res_data  <= 16'h0000;
            res_tag   <= 8'h00;
            for (int i = 0; i < int'(ALU_LAT); i++) pipe_tag[i] <= 8'h00;
        end else begin
            for (int i = int'(ALU_LAT) - 1; i > 0; i--) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
            pipe_vld[0] <= track_d;
            pipe_tag[0] <= tag;
            res_valid   <= pipe_vld[ALU_LAT-1];
            if (pipe_vld[ALU_LAT-1]) begin
                res_data <= alu_out;
                res_tag  <= pipe_tag[ALU_LAT-1];
            end
        end
    end

endmodule

// File: doc/dp_issue_ctrl.md
Name: dp_issue_ctrl

Overview:
Issue controller for the 16-bit lab datapath. It buffers a stream of commands from a requester in a small FIFO and issues one command per cycle onto the datapath's Instruction/DataInit/InitSel inputs. It tracks each issued ALU operation through the datapath latency and reports ALUOut with a tag. It stops at a HALT opcode and drains the pipeline before signalling done.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
ALU_LAT, 1, cycles from dp_* change to valid ALUOut (>=1)
HALT_OP, 4'hF, opcode (instr[15:12]) that ends a run
NOP_INSTR, 16'h0000, instruction driven on bubble cycles

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high; clears all state
start  in  1  one-cycle pulse; begins issuing (IDLE/DONE only)
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept
cmd_is_init  in  1  command is a register init (drives InitSel=1)
cmd_instr  in  16  instruction word
cmd_data  in  16  init data
dp_instr  out  16  to datapath Instruction
dp_data_init  out  16  to datapath DataInit
dp_init_sel  out  1  to datapath InitSel
alu_out  in  16  from datapath ALUOut
res_valid  out  1  result strobe, one cycle per tracked op
res_data  out  16  captured alu_out
res_tag  out  8  issue tag of the op producing res_data
busy  out  1  state is RUN or DRAIN
done  out  1  high in DONE

Behaviour:
- Reset: FIFO empty, state IDLE, dp_instr=NOP_INSTR, dp_data_init=0, dp_init_sel=0, res_valid=0, res_data=0, res_tag=0, issue tag=0, busy=0, done=0. Reset mid-run flushes the FIFO and all in-flight tracking. No res_valid is asserted for ops issued before reset.
- cmd_ready = !full, independent of pop, with no combinational path from cmd_valid. A push occurs when cmd_valid && cmd_ready. Push while full is impossible. A simultaneous push and pop when not full keeps the count unchanged.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: pushes accepted, nothing popped, dp_* hold the bubble values. start -> RUN.
- RUN: each cycle, if the FIFO is non-empty, pop the head at the edge.
  - Non-halt entry: dp_instr/dp_data_init/dp_init_sel are registered from the entry at the same edge.
  - Empty FIFO: bubble (NOP_INSTR, 0, 0).
  - Head opcode == HALT_OP: the entry is popped but drives a bubble; go to DRAIN. Later entries stay in the FIFO.
- DRAIN: bubbles only. Go to DONE when the tracking pipe is empty, which takes exactly ALU_LAT cycles after the HALT pop.
- DONE: done=1, pushes still accepted. start -> RUN, done falls on that edge.
- start outside IDLE/DONE is ignored.
- Tracking: every issued non-init, non-bubble command is assigned the current tag, and the tag then increments mod 256 (wraps 255 -> 0). Init commands and bubbles get no tag and produce no result.
- Tracking pipe: an ALU_LAT-deep shift register of {valid, tag}. If dp_* update at edge E, then at edge E+ALU_LAT: res_valid=1, res_data=alu_out sampled at that edge, res_tag=tag. Otherwise res_valid=0, while res_data and res_tag hold their values.
- Back-to-back ops yield back-to-back results. Throughput is 1 op/cycle; there is no hazard checking, so ordering dependencies are the requester's responsibility.

Test Plan:
- Reset then idle: after reset, cmd_ready=1, dp_instr=16'h0000, dp_init_sel=0, res_valid=0, done=0. Pushing 4 commands with DEPTH=4 gives cmd_ready=0 on the cycle after the 4th push, and no dp_* change occurs while IDLE.
- Init then op: push init(instr=16'h0100, data=16'h0005), init(16'h0200, 16'h0003), ADD 16'h1312, HALT 16'hF000, then start.
  - Required: dp_init_sel=1 for two consecutive cycles with DataInit 5 then 3, then dp_instr=16'h1312 with dp_init_sel=0.
  - res_valid fires once, ALU_LAT cycles later, with res_tag=0 and res_data=alu_out=16'h0008.
  - done rises ALU_LAT cycles after the HALT pop.
- Starvation: in RUN with the FIFO empty for 3 cycles, bubbles are issued and res_valid stays 0. A push then issues on the next edge with no lost or duplicated command.
- Tag wrap: issue 257 ADDs followed by HALT. Tags run 0..255 then 0, and exactly 257 res_valid pulses occur.
- Halt with leftovers: push ADD, HALT, ADD(16'h2123), then start. After DONE the FIFO holds 1 entry. A second start issues 16'h2123 with res_tag=1.
- Reset mid-run: assert reset for 1 cycle while 2 ops are in flight. No res_valid follows, the state is IDLE, the FIFO is empty and the tag is 0.
